// File: rtl/dac_spi_pkg.sv
// Definitions shared by the DAC SPI write link: frame geometry and receiver FSM states.
package dac_spi_pkg;

   localparam int DAC_DATA_WIDTH = 24;
   localparam int DAC_CODE_WIDTH = 16;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      SHIFT
   } rx_state_t;

endpackage

// File: rtl/dac_spi_rx_if.sv
// SPI lines plus the consumer-side word/status port of the DAC SPI receiver.
// slave = receiver view, master = driver/consumer view.
interface dac_spi_rx_if
   import dac_spi_pkg::*;
#(
   parameter int DATA_WIDTH = DAC_DATA_WIDTH,
   parameter int CODE_WIDTH = DAC_CODE_WIDTH,
   parameter int CNT_WIDTH  = 16
);
   logic                  sync_i;
   logic                  sclk_i;
   logic                  sdi_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic [CODE_WIDTH-1:0] code_o;
   logic                  valid_o;
   logic                  ack_i;
   logic                  busy_o;
   logic                  frame_err_o;
   logic                  overrun_o;
   logic                  clr_i;
   logic [CNT_WIDTH-1:0]  frame_cnt_o;

   modport slave (
      input  sync_i, sclk_i, sdi_i, ack_i, clr_i,
      output data_o, code_o, valid_o, busy_o, frame_err_o, overrun_o, frame_cnt_o
   );

   modport master (
      output sync_i, sclk_i, sdi_i, ack_i, clr_i,
      input  data_o, code_o, valid_o, busy_o, frame_err_o, overrun_o, frame_cnt_o
   );

endinterface

// File: rtl/dac_spi_rx_sync_edge.sv
// N-stage synchronizer with level output and registered rise/fall pulses.
// q_o lags d_i by STAGES+1 cycles; rise_o/fall_o are aligned with the q_o change.
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] r_sync;
   logic              r_last;
   logic              r_rise;
   logic              r_fall;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_sync <= {STAGES{RST_VAL}};
         r_last <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d_i};
         r_last <= r_sync[STAGES-1];
         r_rise <= r_sync[STAGES-1] & ~r_last;
         r_fall <= ~r_sync[STAGES-1] & r_last;
      end
   end

   assign q_o    = r_last;
   assign rise_o = r_rise;
   assign fall_o = r_fall;

endmodule

// File: rtl/dac_spi_rx.sv
// SPI slave receiver for the 24-bit DAC write frame; one-entry valid/ack output buffer.
// valid_o rises SYNC_STAGES+2 cycles after sync_i returns high; a frame arriving while full is dropped (overrun).
module dac_spi_rx
   import dac_spi_pkg::*;
#(
   parameter int DATA_WIDTH  = DAC_DATA_WIDTH,
   parameter int CODE_WIDTH  = DAC_CODE_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_EDGE = 0,
   parameter int CNT_WIDTH   = 16
) (
   input logic         clk_i,
   input logic         arstn_i,
   dac_spi_rx_if.slave bus
);

   localparam int             BW        = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0]  FULL      = BW'(DATA_WIDTH);
   localparam int             SETTLE    = SYNC_STAGES + 1;
   localparam int             SW        = $clog2(SETTLE + 1);
   localparam logic           SCLK_IDLE = (SAMPLE_EDGE != 0) ? 1'b0 : 1'b1;

   logic w_sync_q, w_sync_rise, w_sync_fall;
   logic w_sclk_q, w_sclk_rise, w_sclk_fall;
   logic w_sdi_q, w_sdi_rise, w_sdi_fall;
   logic w_sample;
   logic w_unused;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
      .clk_i(clk_i), .arstn_i(arstn_i), .d_i(bus.sync_i),
      .q_o(w_sync_q), .rise_o(w_sync_rise), .fall_o(w_sync_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
      .clk_i(clk_i), .arstn_i(arstn_i), .d_i(bus.sclk_i),
      .q_o(w_sclk_q), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .clk_i(clk_i), .arstn_i(arstn_i), .d_i(bus.sdi_i),
      .q_o(w_sdi_q), .rise_o(w_sdi_rise), .fall_o(w_sdi_fall)
   );

   assign w_sample = (SAMPLE_EDGE != 0) ? w_sclk_rise : w_sclk_fall;
   assign w_unused = &{w_sclk_q, w_sdi_rise, w_sdi_fall};

   rx_state_t             r_state;
   rx_state_t             w_state_nxt;
   logic [DATA_WIDTH-1:0] r_sr;
   logic [BW-1:0]         r_cnt;
   logic                  r_excess;
   logic                  r_eval;
   logic                  r_good;
   logic [SW-1:0]         r_settle;
   logic                  w_settled;
   logic                  w_start, w_shift, w_excess_set, w_end, w_busy;

   // The synchronizers hold their reset values for a few cycles after release, so
   // the real sync level is only trusted once they have flushed.
   assign w_settled = (r_settle == SW'(SETTLE));

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) r_state <= WAIT_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_IDLE: if (w_settled && w_sync_q) w_state_nxt = IDLE;
         IDLE:      if (w_sync_fall)           w_state_nxt = SHIFT;
         SHIFT:     if (w_sync_rise)           w_state_nxt = IDLE;
         default:                              w_state_nxt = WAIT_IDLE;
      endcase
   end

   always_comb begin
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_excess_set = 1'b0;
      w_end        = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         IDLE: w_start = w_sync_fall;
         SHIFT: begin
            w_busy = 1'b1;
            if (w_sync_rise)        w_end        = 1'b1;
            else if (w_sample) begin
               if (r_cnt < FULL)    w_shift      = 1'b1;
               else                 w_excess_set = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Frame verdict is registered so the commit below sees a settled count.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_sr     <= '0;
         r_cnt    <= '0;
         r_excess <= 1'b0;
         r_eval   <= 1'b0;
         r_good   <= 1'b0;
         r_settle <= '0;
      end else begin
         if (!w_settled) r_settle <= r_settle + 1'b1;
         r_eval <= w_end;
         if (w_end) r_good <= (r_cnt == FULL) && !r_excess;
         if (w_start) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_excess <= 1'b0;
         end else if (w_shift) begin
            r_sr  <= {r_sr[DATA_WIDTH-2:0], w_sdi_q};
            r_cnt <= r_cnt + 1'b1;
         end else if (w_excess_set) begin
            r_excess <= 1'b1;
         end
      end
   end

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_frame_err;
   logic                  r_overrun;
   logic [CNT_WIDTH-1:0]  r_frame_cnt;
   logic                  w_commit, w_overrun_set, w_err_set;

   assign w_commit      = r_eval & r_good & (~r_valid | bus.ack_i);
   assign w_overrun_set = r_eval & r_good & r_valid & ~bus.ack_i;
   assign w_err_set     = r_eval & ~r_good;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (w_commit) begin
            r_data      <= r_sr;
            r_valid     <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end else if (bus.ack_i) begin
            r_valid <= 1'b0;
         end
         if (w_err_set)      r_frame_err <= 1'b1;
         else if (bus.clr_i) r_frame_err <= 1'b0;
         if (w_overrun_set)  r_overrun   <= 1'b1;
         else if (bus.clr_i) r_overrun   <= 1'b0;
      end
   end

   assign bus.data_o      = r_data;
   assign bus.code_o      = r_data[CODE_WIDTH-1:0];
   assign bus.valid_o     = r_valid;
   assign bus.busy_o      = w_busy;
   assign bus.frame_err_o = r_frame_err;
   assign bus.overrun_o   = r_overrun;
   assign bus.frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: a falling-edge build and a rising-edge build with a narrow frame counter.
module tb_dac_spi_rx;
   import dac_spi_pkg::*;

   localparam int S0 = 2;
   localparam int S1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic arstn0, arstn1;

   dac_spi_rx_if #(.DATA_WIDTH(24), .CODE_WIDTH(16), .CNT_WIDTH(16)) bus0 ();
   dac_spi_rx_if #(.DATA_WIDTH(24), .CODE_WIDTH(16), .CNT_WIDTH(4))  bus1 ();

   dac_spi_rx #(.DATA_WIDTH(24), .CODE_WIDTH(16), .SYNC_STAGES(S0), .SAMPLE_EDGE(0), .CNT_WIDTH(16))
      u_dut0 (.clk_i(clk), .arstn_i(arstn0), .bus(bus0));

   dac_spi_rx #(.DATA_WIDTH(24), .CODE_WIDTH(16), .SYNC_STAGES(S1), .SAMPLE_EDGE(1), .CNT_WIDTH(4))
      u_dut1 (.clk_i(clk), .arstn_i(arstn1), .bus(bus1));

   int          n_checks = 0;
   int          n_errors = 0;
   logic [23:0] exp_q0[$];
   logic [23:0] exp_q1[$];
   logic [15:0] exp_cnt0 = '0;
   logic [3:0]  exp_cnt1 = '0;
   logic [15:0] seen_cnt0 = '0;
   logic [3:0]  seen_cnt1 = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_lines(input int sel, input logic sy, input logic sc, input logic sd);
      if (sel == 0) begin
         bus0.sync_i = sy; bus0.sclk_i = sc; bus0.sdi_i = sd;
      end else begin
         bus1.sync_i = sy; bus1.sclk_i = sc; bus1.sdi_i = sd;
      end
   endtask

   task automatic pulse_rst(input int sel);
      if (sel == 0) begin arstn0 = 1'b0; exp_cnt0 = '0; end
      else          begin arstn1 = 1'b0; exp_cnt1 = '0; end
      repeat (3) @(negedge clk);
      if (sel == 0) arstn0 = 1'b1;
      else          arstn1 = 1'b1;
   endtask

   // Drives nbits of val MSB first; returns right after sync_i goes high.
   task automatic send_frame(input int sel, input logic [31:0] val, input int nbits, input int rst_at);
      logic idle;
      idle = (sel == 0);
      @(negedge clk);
      set_lines(sel, 1'b0, idle, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         set_lines(sel, 1'b0, idle, val[i]);
         if (rst_at > 0 && (nbits - 1 - i) == rst_at) pulse_rst(sel);
         repeat (3) @(negedge clk);
         set_lines(sel, 1'b0, ~idle, val[i]);
         repeat (3) @(negedge clk);
      end
      set_lines(sel, 1'b0, idle, 1'b0);
      repeat (3) @(negedge clk);
      set_lines(sel, 1'b1, idle, 1'b0);
   endtask

   task automatic send_good(input int sel, input logic [23:0] val);
      if (sel == 0) begin exp_q0.push_back(val); exp_cnt0++; end
      else          begin exp_q1.push_back(val); exp_cnt1++; end
      send_frame(sel, {8'h00, val}, 24, 0);
   endtask

   task automatic wait_valid(input int sel, output int cyc);
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (((sel == 0) ? bus0.valid_o : bus1.valid_o) === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack(input int sel);
      @(negedge clk);
      if (sel == 0) bus0.ack_i = 1'b1; else bus1.ack_i = 1'b1;
      @(negedge clk);
      if (sel == 0) bus0.ack_i = 1'b0; else bus1.ack_i = 1'b0;
   endtask

   task automatic clr(input int sel);
      @(negedge clk);
      if (sel == 0) bus0.clr_i = 1'b1; else bus1.clr_i = 1'b1;
      @(negedge clk);
      if (sel == 0) bus0.clr_i = 1'b0; else bus1.clr_i = 1'b0;
   endtask

   // Every frame_cnt_o step is one committed frame; compare it with the oldest expected word.
   always @(negedge clk) begin
      if (!arstn0) seen_cnt0 = '0;
      else if (bus0.frame_cnt_o !== seen_cnt0) begin
         seen_cnt0 = bus0.frame_cnt_o;
         if (exp_q0.size() == 0) chk("sb0_unexpected_frame", exp_q0.size(), 1);
         else                    chk("sb0_data", bus0.data_o, exp_q0.pop_front());
         chk("sb0_valid", bus0.valid_o, 1);
      end
   end

   always @(negedge clk) begin
      if (!arstn1) seen_cnt1 = '0;
      else if (bus1.frame_cnt_o !== seen_cnt1) begin
         seen_cnt1 = bus1.frame_cnt_o;
         if (exp_q1.size() == 0) chk("sb1_unexpected_frame", exp_q1.size(), 1);
         else                    chk("sb1_data", bus1.data_o, exp_q1.pop_front());
         chk("sb1_valid", bus1.valid_o, 1);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      set_lines(0, 1'b1, 1'b1, 1'b0);
      set_lines(1, 1'b1, 1'b0, 1'b0);
      bus0.ack_i = 1'b0; bus0.clr_i = 1'b0;
      bus1.ack_i = 1'b0; bus1.clr_i = 1'b0;
      arstn0 = 1'b0; arstn1 = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_data",  bus0.data_o, 0);
      chk("rst_valid", bus0.valid_o, 0);
      chk("rst_busy",  bus0.busy_o, 0);
      chk("rst_err",   bus0.frame_err_o, 0);
      chk("rst_ovr",   bus0.overrun_o, 0);
      chk("rst_cnt",   bus0.frame_cnt_o, 0);
      arstn0 = 1'b1; arstn1 = 1'b1;
      idle(10);

      // single frame, latency and status
      send_good(0, 24'h001234);
      wait_valid(0, lat);
      chk("t1_latency", lat - 1, S0 + 2);
      idle(2);
      chk("t1_code", bus0.code_o, 16'h1234);
      chk("t1_cnt",  bus0.frame_cnt_o, exp_cnt0);
      chk("t1_err",  bus0.frame_err_o, 0);
      chk("t1_ovr",  bus0.overrun_o, 0);
      chk("t1_busy", bus0.busy_o, 0);
      ack(0);
      chk("t1_ack_valid", bus0.valid_o, 0);

      // overrun: second frame dropped while the first is pending
      send_good(0, 24'h00ABCD);
      idle(10);
      send_frame(0, 32'h0000FFFF, 24, 0);
      idle(10);
      chk("t2_data",  bus0.data_o, 24'h00ABCD);
      chk("t2_ovr",   bus0.overrun_o, 1);
      chk("t2_valid", bus0.valid_o, 1);
      chk("t2_cnt",   bus0.frame_cnt_o, exp_cnt0);
      ack(0);
      chk("t2_ack_valid", bus0.valid_o, 0);
      clr(0);
      chk("t2_clr_ovr", bus0.overrun_o, 0);

      // short and long frames
      send_frame(0, 32'h007FFFFF, 23, 0);
      idle(10);
      chk("t3_short_err",   bus0.frame_err_o, 1);
      chk("t3_short_valid", bus0.valid_o, 0);
      chk("t3_short_cnt",   bus0.frame_cnt_o, exp_cnt0);
      clr(0);
      chk("t3_clr_err", bus0.frame_err_o, 0);
      send_frame(0, 32'h01555555, 25, 0);
      idle(10);
      chk("t3_long_err",   bus0.frame_err_o, 1);
      chk("t3_long_valid", bus0.valid_o, 0);
      chk("t3_long_cnt",   bus0.frame_cnt_o, exp_cnt0);
      send_good(0, 24'h000001);
      idle(10);
      chk("t3_good_valid",  bus0.valid_o, 1);
      chk("t3_err_sticky",  bus0.frame_err_o, 1);
      chk("t3_good_cnt",    bus0.frame_cnt_o, exp_cnt0);
      ack(0);
      clr(0);

      // ack in the same cycle as the next commit
      send_good(0, 24'h00AAAA);
      idle(10);
      chk("t4_pending", bus0.valid_o, 1);
      exp_q0.push_back(24'h005555);
      exp_cnt0++;
      send_frame(0, 32'h00005555, 24, 0);
      repeat (S0 + 2) @(negedge clk);
      bus0.ack_i = 1'b1;
      @(negedge clk);
      bus0.ack_i = 1'b0;
      chk("t4_data",  bus0.data_o, 24'h005555);
      chk("t4_valid", bus0.valid_o, 1);
      chk("t4_ovr",   bus0.overrun_o, 0);
      chk("t4_cnt",   bus0.frame_cnt_o, exp_cnt0);
      ack(0);

      // reset in the middle of a frame, sync_i still low at release
      send_frame(0, 32'h00F0F0F0, 24, 10);
      idle(10);
      chk("t5_err",   bus0.frame_err_o, 0);
      chk("t5_valid", bus0.valid_o, 0);
      chk("t5_cnt",   bus0.frame_cnt_o, 0);
      send_good(0, 24'h000F0F);
      idle(10);
      chk("t5_next_valid", bus0.valid_o, 1);
      chk("t5_next_cnt",   bus0.frame_cnt_o, exp_cnt0);
      ack(0);

      // rising-edge build, then counter wrap
      send_good(1, 24'h00C3C3);
      wait_valid(1, lat);
      chk("t6_latency", lat - 1, S1 + 2);
      idle(2);
      chk("t6_code", bus1.code_o, 16'hC3C3);
      chk("t6_cnt",  bus1.frame_cnt_o, exp_cnt1);
      ack(1);
      for (int i = 0; i < 14; i++) begin
         send_good(1, 24'($urandom_range(0, 24'hFFFFFF)));
         idle(12);
         ack(1);
      end
      chk("t6_cnt_full", bus1.frame_cnt_o, exp_cnt1);
      send_good(1, 24'h00BEEF);
      idle(12);
      chk("t6_cnt_wrap", bus1.frame_cnt_o, 0);
      chk("t6_wrap_err", bus1.frame_err_o, 0);
      ack(1);

      idle(4);
      chk("sb0_drain", exp_q0.size(), 0);
      chk("sb1_drain", exp_q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
